// File: rtl/lpc_link_pkg.sv
// Constants and state encoding shared by the LPC frame link transmit and receive sides.
package lpc_link_pkg;
    localparam logic [7:0] SYNC_BYTE     = 8'hFF;
    localparam int         SYNC_LEN      = 2;
    localparam int         DEF_FRAME_LEN = 7;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC,
        ST_DATA,
        ST_DISCARD,
        ST_COMMIT
    } link_state_e;
endpackage

// File: rtl/serial_timeout.sv
// Idle watchdog: counts clocks while enabled, restarts on clear, pulses expired after TIMEOUT idle clocks.
module serial_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // A clear in the expiry cycle suppresses the pulse: an arriving byte beats the abort.
    assign expired = enable && !clear && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear || !enable || expired)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/serial2mem.sv
// LPC link receiver: finds the FF FF sync in the UART byte stream and writes the
// following FRAME_LEN payload bytes into one frame-buffer slot, then commits it.
module serial2mem
    import lpc_link_pkg::*;
#(
    parameter int AW        = 8,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int TIMEOUT   = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    uart_data,
    input  logic          uart_valid,
    input  logic [AW-4:0] target_addr,
    input  logic          write_full,
    output logic          write_clock,
    output logic [7:0]    write_data,
    output logic [AW-1:0] write_addr,
    output logic          write_done,
    output logic          frame_error,
    output logic [7:0]    drop_count
);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    link_state_e   state, state_nx;
    logic [2:0]    idx;
    logic [AW-4:0] slot;
    logic          is_sync, in_frame, tmo_en, expired;

    assign is_sync  = uart_valid && (uart_data == SYNC_BYTE);
    assign in_frame = (state == ST_DATA) || (state == ST_DISCARD);
    assign tmo_en   = in_frame || (state == ST_SYNC);

    serial_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (uart_valid),
        .enable  (tmo_en),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_HUNT;
        else
            state <= state_nx;
    end

    // expired is never set in a cycle carrying a byte, so checking it first is safe.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_HUNT:    if (is_sync) state_nx = ST_SYNC;
            ST_SYNC: begin
                if (expired)
                    state_nx = ST_HUNT;
                else if (uart_valid)
                    state_nx = !is_sync ? ST_HUNT : (write_full ? ST_DISCARD : ST_DATA);
            end
            ST_DATA: begin
                if (expired)
                    state_nx = ST_HUNT;
                else if (uart_valid && idx == LAST_IDX)
                    state_nx = ST_COMMIT;
            end
            ST_DISCARD: begin
                if (expired || (uart_valid && idx == LAST_IDX))
                    state_nx = ST_HUNT;
            end
            ST_COMMIT:  state_nx = is_sync ? ST_SYNC : ST_HUNT;
            default:    state_nx = ST_HUNT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            slot        <= '0;
            write_clock <= 1'b0;
            write_data  <= '0;
            write_addr  <= '0;
            write_done  <= 1'b0;
            frame_error <= 1'b0;
            drop_count  <= '0;
        end else begin
            write_clock <= 1'b0;
            write_done  <= (state == ST_COMMIT);
            frame_error <= expired && in_frame;
            if (state == ST_SYNC && is_sync) begin
                slot <= target_addr;
                idx  <= '0;
                if (write_full && drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
            if (in_frame && uart_valid)
                idx <= idx + 3'd1;
            if (state == ST_DATA && uart_valid) begin
                write_clock <= 1'b1;
                write_data  <= uart_data;
                write_addr  <= {slot, idx};
            end
        end
    end
endmodule

// File: tb/tb_serial2mem.sv
// Randomized bench for serial2mem against a byte-stream reference model of the frame rules.
module tb_serial2mem;
    localparam int AW = 8;
    localparam int FL = 7;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    uart_data = '0;
    logic          uart_valid = 1'b0;
    logic [AW-4:0] target_addr = '0;
    logic          write_full = 1'b0;
    logic          write_clock, write_done, frame_error;
    logic [7:0]    write_data, drop_count;
    logic [AW-1:0] write_addr;

    serial2mem #(.AW(AW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_data   (uart_data),
        .uart_valid  (uart_valid),
        .target_addr (target_addr),
        .write_full  (write_full),
        .write_clock (write_clock),
        .write_data  (write_data),
        .write_addr  (write_addr),
        .write_done  (write_done),
        .frame_error (frame_error),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: 0 = looking for sync, 1 = one FF seen, 2 = frame kept, 3 = frame dropped
    int         m_mode, m_idx, m_idle, m_drop;
    logic [4:0] m_slot;
    bit         m_done_pend;
    bit         e_wc, e_done, e_err;
    logic [7:0] e_wd, e_wa, e_drop;

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_idle = 0; m_drop = 0; m_slot = '0; m_done_pend = 0;
    endtask

    // Consumes one clock of input; sets the outputs expected during the following clock.
    task automatic model_step(input bit v, input logic [7:0] d);
        e_wc = 0; e_err = 0;
        e_done = m_done_pend; m_done_pend = 0;
        if (v) begin
            m_idle = 0;
            case (m_mode)
                0: if (d == 8'hFF) m_mode = 1;
                1: begin
                    if (d == 8'hFF) begin
                        m_slot = target_addr;
                        m_idx  = 0;
                        if (write_full) begin
                            m_mode = 3;
                            if (m_drop < 255) m_drop++;
                        end else m_mode = 2;
                    end else m_mode = 0;
                end
                2: begin
                    e_wc = 1; e_wd = d; e_wa = m_slot * 8 + m_idx;
                    m_idx++;
                    if (m_idx == FL) begin m_mode = 0; m_done_pend = 1; end
                end
                default: begin
                    m_idx++;
                    if (m_idx == FL) m_mode = 0;
                end
            endcase
        end else if (m_mode != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                e_err  = (m_mode >= 2);
                m_mode = 0;
            end
        end
        e_drop = 8'(m_drop);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        uart_valid = v;
        uart_data  = v ? d : 8'h00;
        model_step(v, d);
        @(posedge clock);
        @(negedge clock);
        uart_valid = 1'b0;
        chk("write_clock", write_clock, e_wc);
        if (e_wc) begin
            chk("write_addr", write_addr, e_wa);
            chk("write_data", write_data, e_wd);
        end
        chk("write_done", write_done, e_done);
        chk("frame_error", frame_error, e_err);
        chk("drop_count", drop_count, e_drop);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        cycle(1'b1, d);
        repeat (gap) cycle(1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wc"},   write_clock, 0);
        chk({tag, "_wd"},   write_data,  0);
        chk({tag, "_wa"},   write_addr,  0);
        chk({tag, "_done"}, write_done,  0);
        chk({tag, "_err"},  frame_error, 0);
        chk({tag, "_drop"}, drop_count,  0);
    endtask

    int gap;

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;
        idle(2);

        // Basic frame, gaps of 3 clocks, slot 3 -> addresses 0x18..0x1E
        target_addr = 5'h03;
        send(8'hFF, 3); send(8'hFF, 3);
        for (int i = 1; i <= FL; i++) send(8'(i), 3);
        idle(3);

        // All-FF payload must not re-sync
        target_addr = 5'h11;
        send(8'hFF, 0); send(8'hFF, 0);
        for (int i = 0; i < FL; i++) send(8'hFF, 1);
        idle(3);

        // Broken sync then real sync
        target_addr = 5'h07;
        send(8'hFF, 0); send(8'h12, 0); send(8'hFF, 0); send(8'hFF, 0);
        for (int i = 0; i < FL; i++) send(8'h0A + 8'(i), 0);
        idle(3);

        // Full at sync: frame dropped, then normal frame; full changes mid-frame are ignored
        write_full = 1'b1;
        send(8'hFF, 0); send(8'hFF, 0);
        write_full = 1'b0;
        for (int i = 0; i < FL; i++) send(8'h30 + 8'(i), 1);
        target_addr = 5'h1F;
        send(8'hFF, 0); send(8'hFF, 0);
        write_full = 1'b1; target_addr = 5'h00;
        for (int i = 0; i < FL; i++) send(8'h40 + 8'(i), 0);
        write_full = 1'b0;
        idle(3);

        // Timeout mid-frame, then fresh frame from index 0
        target_addr = 5'h05;
        send(8'hFF, 0); send(8'hFF, 0); send(8'h01, 0); send(8'h02, TO + 4);
        send(8'hFF, 0); send(8'hFF, 0);
        for (int i = 0; i < FL; i++) send(8'h09 + 8'(i), 0);
        idle(3);

        // Byte lands exactly on the expiry cycle: no abort
        send(8'hFF, TO - 1); send(8'hFF, TO - 1);
        for (int i = 0; i < FL; i++) send(8'h50 + 8'(i), TO - 1);
        idle(3);
        // Timeout while only half-synced: silent return to hunt
        send(8'hFF, TO + 2);
        idle(2);

        // Reset mid-frame with a write strobe in flight
        send(8'hFF, 0); send(8'hFF, 0);
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
        #2 reset = 1'b0;
        #1 check_outputs_zero("midreset");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        target_addr = 5'h0C;
        send(8'hFF, 0); send(8'hFF, 0);
        for (int i = 0; i < FL; i++) send(8'h60 + 8'(i), 0);
        idle(3);

        // Random traffic: junk, random payload, random slot/full, occasional stalls
        for (int f = 0; f < 200; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                send(8'($urandom), $urandom_range(0, 2));
            target_addr = 5'($urandom);
            write_full  = ($urandom_range(0, 4) == 0);
            send(8'hFF, $urandom_range(0, 2));
            send(8'hFF, $urandom_range(0, 2));
            for (int i = 0; i < FL; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    target_addr = 5'($urandom);
                    write_full  = ~write_full;
                end
                case ($urandom_range(0, 40))
                    0:       gap = TO - 1;
                    1:       gap = TO;
                    2:       gap = TO + 3;
                    default: gap = $urandom_range(0, 3);
                endcase
                send(($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom), gap);
            end
        end
        idle(4);

        // Drop counter saturation
        write_full = 1'b1;
        for (int f = 0; f < 260; f++) begin
            send(8'hFF, 0); send(8'hFF, 0);
            for (int i = 0; i < FL; i++) send(8'($urandom), 0);
        end
        write_full = 1'b0;
        idle(2);
        chk("drop_sat", drop_count, 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
